ma_stage_hs: RTL and testbench

- Parametrised memory-access pipeline stage for the RISC-V core. It sits between EX and WB.
- Talks to a data memory through a valid/ready request channel and a valid-only response channel, so memory latency can vary.
- Handles XLEN 32 or 64, all RV load/store widths with sign/zero extension, and byte-lane write masks.
- Detects misaligned or illegal accesses and stalls upstream while a memory transaction is pending.

---
 rtl/ma_stage_hs.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_ma_stage_hs.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ma_stage_hs.sv
// ma_stage_hs -- memory-access pipeline stage (between EX and WB).
//
// Purpose:
//   Turns loads/stores coming out of EX into requests on a data-memory
//   valid/ready request channel and collects read data from a valid-only
//   response channel, so memory latency may vary. Non-memory instructions
//   pass straight through with one cycle of latency. Misaligned or
//   width-illegal accesses never reach memory; they retire with a one-cycle
//   exception pulse instead.
//
// Handshake semantics (request channel):
//   A request transfers on a cycle where mem_req_valid && mem_req_ready.
//   Once mem_req_valid is raised it stays high, with we/addr/wdata/mask
//   unchanged, until that transfer happens; a request is never withdrawn.
//   The response channel has no ready: mem_rsp_valid is accepted only in
//   WAIT and must arrive no earlier than the cycle after the transfer.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid / in_ready            instruction from EX / stage can accept
//   alu_out, rd, rf_wb_en          effective address or ALU result, dest reg
//   st_data, mem_rd, mem_wr, funct3  store data, load/store flags, width code
//   mem_req_*                      data-memory request channel
//   mem_rsp_valid, mem_rsp_data    data-memory response channel
//   wb_valid, wb_en, wb_rd, wb_data  retire / writeback outputs
//   exc_misalign, exc_addr         misaligned/illegal access pulse + address
//   stall                          hold upstream stages
//   dbg_state                      current FSM state (0 IDLE, 1 REQ, 2 WAIT)

module ma_stage_hs #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int NB     = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   alu_out,
  input  logic [4:0]        rd,
  input  logic              rf_wb_en,
  input  logic [XLEN-1:0]   st_data,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        funct3,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [NB-1:0]     mem_req_mask,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              exc_misalign,
  output logic [XLEN-1:0]   exc_addr,
  output logic              stall,
  output logic [1:0]        dbg_state
);

  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------
  state_t             state_q, state_d;
  logic               req_we_q, req_we_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [XLEN-1:0]    req_wdata_q, req_wdata_d;
  logic [NB-1:0]      req_mask_q, req_mask_d;
  logic [OFF_W-1:0]   ld_off_q, ld_off_d;
  logic [1:0]         ld_size_q, ld_size_d;
  logic               ld_unsigned_q, ld_unsigned_d;
  logic [4:0]         rd_q, rd_d;
  logic               rf_wb_en_q, rf_wb_en_d;
  logic               wb_valid_q, wb_valid_d;
  logic               wb_en_q, wb_en_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]    wb_data_q, wb_data_d;
  logic               exc_q, exc_d;
  logic [XLEN-1:0]    exc_addr_q, exc_addr_d;

  // ---------------------------------------------------------------------
  // Access decode for the instruction presented by EX
  // ---------------------------------------------------------------------
  logic [1:0]         size;         // log2 of access bytes
  logic               is_unsigned;
  logic               f3_legal;
  logic [OFF_W-1:0]   off;
  logic [OFF_W-1:0]   align_mask;
  logic               access_legal;
  logic               mem_op;
  logic               idle_req;
  logic [NB-1:0]      size_bmask;
  logic [NB-1:0]      req_mask_c;
  logic [XLEN-1:0]    req_wdata_c;
  logic [ADDR_W-1:0]  req_addr_c;

  always_comb begin
    size        = funct3[1:0];
    is_unsigned = funct3[2];
    f3_legal    = 1'b1;
    case (funct3)
      3'b011, 3'b110: f3_legal = (XLEN == 64);  // D / WU need a 64-bit datapath
      3'b111:         f3_legal = 1'b0;
      default:        f3_legal = 1'b1;
    endcase
  end

  assign off          = alu_out[OFF_W-1:0];
  assign align_mask   = OFF_W'((4'd1 << size) - 4'd1);
  assign access_legal = f3_legal && ((off & align_mask) == '0);
  assign mem_op       = mem_rd || mem_wr;
  assign idle_req     = (state_q == S_IDLE) && in_valid && mem_op && access_legal;

  always_comb begin
    case (size)
      2'd0:    size_bmask = NB'(8'h01);
      2'd1:    size_bmask = NB'(8'h03);
      2'd2:    size_bmask = NB'(8'h0F);
      default: size_bmask = NB'(8'hFF);
    endcase
  end

  // Store data moves to its byte lane; reads carry no mask and no data.
  assign req_mask_c  = mem_wr ? (size_bmask << off) : '0;
  assign req_wdata_c = mem_wr ? (st_data << {off, 3'b000}) : '0;
  assign req_addr_c  = {alu_out[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // ---------------------------------------------------------------------
  // Load-data lane select and extension (uses registered offset/width)
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] rsp_shift;
  logic [XLEN-1:0] ld_ext;

  always_comb begin
    rsp_shift = mem_rsp_data >> {ld_off_q, 3'b000};
    case (ld_size_q)
      2'd0:    ld_ext = ld_unsigned_q ? XLEN'(rsp_shift[7:0])
                                      : XLEN'($signed(rsp_shift[7:0]));
      2'd1:    ld_ext = ld_unsigned_q ? XLEN'(rsp_shift[15:0])
                                      : XLEN'($signed(rsp_shift[15:0]));
      2'd2:    ld_ext = ld_unsigned_q ? XLEN'(rsp_shift[31:0])
                                      : XLEN'($signed(rsp_shift[31:0]));
      default: ld_ext = rsp_shift;
    endcase
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    req_we_d      = req_we_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    req_mask_d    = req_mask_q;
    ld_off_d      = ld_off_q;
    ld_size_d     = ld_size_q;
    ld_unsigned_d = ld_unsigned_q;
    rd_d          = rd_q;
    rf_wb_en_d    = rf_wb_en_q;
    wb_valid_d    = 1'b0;
    wb_en_d       = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    exc_d         = 1'b0;
    exc_addr_d    = exc_addr_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!mem_op) begin
            wb_valid_d = 1'b1;
            wb_en_d    = rf_wb_en;
            wb_rd_d    = rd;
            wb_data_d  = alu_out;
          end else if (!access_legal) begin
            // Retire as a non-writing instruction that flags the fault.
            wb_valid_d = 1'b1;
            exc_d      = 1'b1;
            exc_addr_d = alu_out;
          end else begin
            // Capture everything now so REQ can replay the request
            // unchanged and WAIT knows how to extract the load data.
            req_we_d      = mem_wr;
            req_addr_d    = req_addr_c;
            req_wdata_d   = req_wdata_c;
            req_mask_d    = req_mask_c;
            ld_off_d      = off;
            ld_size_d     = size;
            ld_unsigned_d = is_unsigned;
            rd_d          = rd;
            rf_wb_en_d    = rf_wb_en;
            if (mem_req_ready) begin
              if (mem_wr) wb_valid_d = 1'b1;
              else        state_d    = S_WAIT;
            end else begin
              state_d = S_REQ;
            end
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          if (req_we_q) begin
            wb_valid_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          wb_valid_d = 1'b1;
          wb_en_d    = rf_wb_en_q;
          wb_rd_d    = rd_q;
          wb_data_d  = ld_ext;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers (reset abandons any pending transaction)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_we_q      <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      req_mask_q    <= '0;
      ld_off_q      <= '0;
      ld_size_q     <= '0;
      ld_unsigned_q <= 1'b0;
      rd_q          <= '0;
      rf_wb_en_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_en_q       <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      exc_q         <= 1'b0;
      exc_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      req_we_q      <= req_we_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      req_mask_q    <= req_mask_d;
      ld_off_q      <= ld_off_d;
      ld_size_q     <= ld_size_d;
      ld_unsigned_q <= ld_unsigned_d;
      rd_q          <= rd_d;
      rf_wb_en_q    <= rf_wb_en_d;
      wb_valid_q    <= wb_valid_d;
      wb_en_q       <= wb_en_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      exc_q         <= exc_d;
      exc_addr_q    <= exc_addr_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: request comes straight from EX in IDLE, from registers in REQ
  // ---------------------------------------------------------------------
  logic in_req;
  assign in_req = (state_q == S_REQ);

  assign mem_req_valid = idle_req || in_req;
  assign mem_req_we    = in_req ? req_we_q    : (idle_req && mem_wr);
  assign mem_req_addr  = in_req ? req_addr_q  : (idle_req ? req_addr_c  : '0);
  assign mem_req_wdata = in_req ? req_wdata_q : (idle_req ? req_wdata_c : '0);
  assign mem_req_mask  = in_req ? req_mask_q  : (idle_req ? req_mask_c  : '0);

  assign stall     = (state_q != S_IDLE) || (idle_req && !mem_req_ready);
  assign in_ready  = !stall;

  assign wb_valid     = wb_valid_q;
  assign wb_en        = wb_en_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign exc_misalign = exc_q;
  assign exc_addr     = exc_addr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ma_stage_hs.sv
// tb_ma_stage_hs -- directed testbench for ma_stage_hs.
// Instance a is the default XLEN=32 build, instance b is XLEN=64.
// Inputs are driven on the falling edge; registered results of a rising
// edge are checked at the following falling edge, combinational request
// outputs #1 after the inputs change.

module tb_ma_stage_hs;

  // -------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // -------------------------------------------------------------------
  // XLEN=32 instance signals
  // -------------------------------------------------------------------
  logic        a_in_valid, a_in_ready, a_rf_wb_en, a_mem_rd, a_mem_wr;
  logic [31:0] a_alu_out, a_st_data, a_mem_req_addr, a_mem_req_wdata;
  logic [31:0] a_mem_rsp_data, a_wb_data, a_exc_addr;
  logic [4:0]  a_rd, a_wb_rd;
  logic [2:0]  a_funct3;
  logic        a_mem_req_valid, a_mem_req_ready, a_mem_req_we;
  logic [3:0]  a_mem_req_mask;
  logic        a_mem_rsp_valid, a_wb_valid, a_wb_en, a_exc, a_stall;
  logic [1:0]  a_state;

  ma_stage_hs #(.XLEN(32), .ADDR_W(32)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .alu_out(a_alu_out), .rd(a_rd), .rf_wb_en(a_rf_wb_en),
    .st_data(a_st_data), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .funct3(a_funct3),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(a_mem_req_ready),
    .mem_req_we(a_mem_req_we), .mem_req_addr(a_mem_req_addr),
    .mem_req_wdata(a_mem_req_wdata), .mem_req_mask(a_mem_req_mask),
    .mem_rsp_valid(a_mem_rsp_valid), .mem_rsp_data(a_mem_rsp_data),
    .wb_valid(a_wb_valid), .wb_en(a_wb_en), .wb_rd(a_wb_rd), .wb_data(a_wb_data),
    .exc_misalign(a_exc), .exc_addr(a_exc_addr), .stall(a_stall),
    .dbg_state(a_state)
  );

  // -------------------------------------------------------------------
  // XLEN=64 instance signals
  // -------------------------------------------------------------------
  logic        b_in_valid, b_in_ready, b_rf_wb_en, b_mem_rd, b_mem_wr;
  logic [63:0] b_alu_out, b_st_data, b_mem_req_wdata;
  logic [63:0] b_mem_rsp_data, b_wb_data, b_exc_addr;
  logic [31:0] b_mem_req_addr;
  logic [4:0]  b_rd, b_wb_rd;
  logic [2:0]  b_funct3;
  logic        b_mem_req_valid, b_mem_req_ready, b_mem_req_we;
  logic [7:0]  b_mem_req_mask;
  logic        b_mem_rsp_valid, b_wb_valid, b_wb_en, b_exc, b_stall;
  logic [1:0]  b_state;

  ma_stage_hs #(.XLEN(64), .ADDR_W(32)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .alu_out(b_alu_out), .rd(b_rd), .rf_wb_en(b_rf_wb_en),
    .st_data(b_st_data), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .funct3(b_funct3),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready),
    .mem_req_we(b_mem_req_we), .mem_req_addr(b_mem_req_addr),
    .mem_req_wdata(b_mem_req_wdata), .mem_req_mask(b_mem_req_mask),
    .mem_rsp_valid(b_mem_rsp_valid), .mem_rsp_data(b_mem_rsp_data),
    .wb_valid(b_wb_valid), .wb_en(b_wb_en), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
    .exc_misalign(b_exc), .exc_addr(b_exc_addr), .stall(b_stall),
    .dbg_state(b_state)
  );

  // -------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------
  task automatic a_idle();
    a_in_valid = 1'b0; a_alu_out = '0; a_rd = '0; a_rf_wb_en = 1'b0;
    a_st_data = '0; a_mem_rd = 1'b0; a_mem_wr = 1'b0; a_funct3 = '0;
    a_mem_req_ready = 1'b1; a_mem_rsp_valid = 1'b0; a_mem_rsp_data = '0;
  endtask

  task automatic b_idle();
    b_in_valid = 1'b0; b_alu_out = '0; b_rd = '0; b_rf_wb_en = 1'b0;
    b_st_data = '0; b_mem_rd = 1'b0; b_mem_wr = 1'b0; b_funct3 = '0;
    b_mem_req_ready = 1'b1; b_mem_rsp_valid = 1'b0; b_mem_rsp_data = '0;
  endtask

  task automatic a_issue(input logic [31:0] alu, input logic [4:0] r, input logic we,
                         input logic [31:0] sd, input logic ld, input logic st,
                         input logic [2:0] f3, input logic rdy);
    a_in_valid = 1'b1; a_alu_out = alu; a_rd = r; a_rf_wb_en = we;
    a_st_data = sd; a_mem_rd = ld; a_mem_wr = st; a_funct3 = f3;
    a_mem_req_ready = rdy;
  endtask

  task automatic b_issue(input logic [63:0] alu, input logic [4:0] r, input logic ld,
                         input logic [2:0] f3);
    b_in_valid = 1'b1; b_alu_out = alu; b_rd = r; b_rf_wb_en = 1'b1;
    b_st_data = '0; b_mem_rd = ld; b_mem_wr = 1'b0; b_funct3 = f3;
    b_mem_req_ready = 1'b1;
  endtask

  // -------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    a_idle(); b_idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", a_stall); end
    total++; if (a_wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b exp=0", a_wb_valid); end
    total++; if (a_mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", a_mem_req_valid); end
    total++; if (a_wb_data !== 32'h0) begin bad++; $display("FAIL reset_wb_data got=%h exp=0", a_wb_data); end
    total++; if (a_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", a_state); end
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL reset_b_in_ready got=%b exp=1", b_in_ready); end
  endtask

  task automatic test_alu_op();
    int stall_seen;
    stall_seen = 0;
    @(negedge clk);
    a_issue(32'h1234_5678, 5'd5, 1'b1, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1);
    #1;
    if (a_stall) stall_seen++;
    @(negedge clk);
    if (a_stall) stall_seen++;
    total++; if (a_wb_valid !== 1'b1) begin bad++; $display("FAIL alu_wb_valid got=%b exp=1", a_wb_valid); end
    total++; if (a_wb_en !== 1'b1) begin bad++; $display("FAIL alu_wb_en got=%b exp=1", a_wb_en); end
    total++; if (a_wb_rd !== 5'd5) begin bad++; $display("FAIL alu_wb_rd got=%0d exp=5", a_wb_rd); end
    total++; if (a_wb_data !== 32'h1234_5678) begin bad++; $display("FAIL alu_wb_data got=%h exp=12345678", a_wb_data); end
    a_idle();
    @(negedge clk);
    total++; if (a_wb_valid !== 1'b0) begin bad++; $display("FAIL alu_wb_valid_drop got=%b exp=0", a_wb_valid); end
    total++; if (a_wb_data !== 32'h1234_5678) begin bad++; $display("FAIL alu_wb_data_hold got=%h exp=12345678", a_wb_data); end
    total++; if (stall_seen !== 0) begin bad++; $display("FAIL alu_no_stall got=%0d exp=0", stall_seen); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a_issue(32'h0000_00A1, 5'd1, 1'b1, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1);
    @(negedge clk);
    a_issue(32'h0000_00B2, 5'd2, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1);
    total++; if (a_wb_data !== 32'hA1 || a_wb_rd !== 5'd1 || a_wb_en !== 1'b1)
      begin bad++; $display("FAIL b2b_first got=%h/%0d/%b exp=a1/1/1", a_wb_data, a_wb_rd, a_wb_en); end
    @(negedge clk);
    a_idle();
    total++; if (a_wb_valid !== 1'b1 || a_wb_data !== 32'hB2 || a_wb_rd !== 5'd2 || a_wb_en !== 1'b0)
      begin bad++; $display("FAIL b2b_second got=%b/%h/%0d/%b exp=1/b2/2/0", a_wb_valid, a_wb_data, a_wb_rd, a_wb_en); end
  endtask

  // Byte load at 0x1003, response on the fourth WAIT cycle.
  task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp_data, input string nm);
    int stall_cnt;
    stall_cnt = 0;
    @(negedge clk);
    a_issue(32'h0000_1003, 5'd7, 1'b1, 32'h0, 1'b1, 1'b0, f3, 1'b1);
    #1;
    total++; if (a_mem_req_valid !== 1'b1 || a_mem_req_addr !== 32'h1000 || a_mem_req_we !== 1'b0 || a_mem_req_mask !== 4'b0000)
      begin bad++; $display("FAIL %s_req got=%b/%h/%b/%b exp=1/1000/0/0000", nm, a_mem_req_valid, a_mem_req_addr, a_mem_req_we, a_mem_req_mask); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_idle();
      if (a_stall) stall_cnt++;
      if (i == 3) begin
        a_mem_rsp_valid = 1'b1;
        a_mem_rsp_data  = 32'h80AA_BBCC;
      end
    end
    @(negedge clk);
    a_idle();
    total++; if (stall_cnt !== 4) begin bad++; $display("FAIL %s_stall_cycles got=%0d exp=4", nm, stall_cnt); end
    total++; if (a_wb_valid !== 1'b1 || a_wb_en !== 1'b1 || a_wb_rd !== 5'd7)
      begin bad++; $display("FAIL %s_retire got=%b/%b/%0d exp=1/1/7", nm, a_wb_valid, a_wb_en, a_wb_rd); end
    total++; if (a_wb_data !== exp_data) begin bad++; $display("FAIL %s_data got=%h exp=%h", nm, a_wb_data, exp_data); end
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL %s_stall_release got=%b exp=0", nm, a_stall); end
  endtask

  task automatic test_store_backpressure();
    @(negedge clk);
    a_issue(32'h0000_2002, 5'd0, 1'b0, 32'h0000_BEEF, 1'b0, 1'b1, 3'b001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (a_mem_req_valid !== 1'b1 || a_mem_req_we !== 1'b1 || a_mem_req_addr !== 32'h2000 ||
                   a_mem_req_mask !== 4'b1100 || a_mem_req_wdata[31:16] !== 16'hBEEF || a_stall !== 1'b1)
        begin bad++; $display("FAIL sh_req_cycle%0d got=%b/%b/%h/%b/%h/%b exp=1/1/2000/1100/beef..../1", i,
                              a_mem_req_valid, a_mem_req_we, a_mem_req_addr, a_mem_req_mask, a_mem_req_wdata, a_stall); end
      @(negedge clk);
      // EX side changes: the held request must not follow it.
      a_in_valid = 1'b0; a_alu_out = 32'hDEAD_0001; a_st_data = 32'h5555_5555;
      a_mem_req_ready = (i == 1);
    end
    a_idle();
    total++; if (a_wb_valid !== 1'b1 || a_wb_en !== 1'b0)
      begin bad++; $display("FAIL sh_retire got=%b/%b exp=1/0", a_wb_valid, a_wb_en); end
    total++; if (a_mem_req_valid !== 1'b0 || a_state !== 2'd0)
      begin bad++; $display("FAIL sh_idle got=%b/%0d exp=0/0", a_mem_req_valid, a_state); end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    a_issue(32'h0000_3002, 5'd9, 1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1);
    #1;
    total++; if (a_mem_req_valid !== 1'b0 || a_stall !== 1'b0)
      begin bad++; $display("FAIL lw_mis_noreq got=%b/%b exp=0/0", a_mem_req_valid, a_stall); end
    @(negedge clk);
    a_idle();
    total++; if (a_exc !== 1'b1 || a_exc_addr !== 32'h3002 || a_wb_valid !== 1'b1 || a_wb_en !== 1'b0)
      begin bad++; $display("FAIL lw_mis_exc got=%b/%h/%b/%b exp=1/3002/1/0", a_exc, a_exc_addr, a_wb_valid, a_wb_en); end
    @(negedge clk);
    total++; if (a_exc !== 1'b0) begin bad++; $display("FAIL lw_mis_pulse got=%b exp=0", a_exc); end
    // LD is not a legal width on a 32-bit datapath even when aligned.
    a_issue(32'h0000_0008, 5'd9, 1'b1, 32'h0, 1'b1, 1'b0, 3'b011, 1'b1);
    #1;
    total++; if (a_mem_req_valid !== 1'b0) begin bad++; $display("FAIL ld32_noreq got=%b exp=0", a_mem_req_valid); end
    @(negedge clk);
    a_idle();
    total++; if (a_exc !== 1'b1 || a_exc_addr !== 32'h8)
      begin bad++; $display("FAIL ld32_exc got=%b/%h exp=1/8", a_exc, a_exc_addr); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    a_issue(32'h0000_4000, 5'd3, 1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1);
    @(negedge clk);
    a_idle();
    total++; if (a_state !== 2'd2 || a_stall !== 1'b1)
      begin bad++; $display("FAIL rstw_in_wait got=%0d/%b exp=2/1", a_state, a_stall); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (a_state !== 2'd0 || a_in_ready !== 1'b1)
      begin bad++; $display("FAIL rstw_idle got=%0d/%b exp=0/1", a_state, a_in_ready); end
    @(negedge clk);
    a_mem_rsp_valid = 1'b1;
    a_mem_rsp_data  = 32'h7777_7777;
    @(negedge clk);
    a_idle();
    total++; if (a_wb_valid !== 1'b0 || a_wb_data !== 32'h0 || a_state !== 2'd0 || a_in_ready !== 1'b1)
      begin bad++; $display("FAIL rstw_ignore got=%b/%h/%0d/%b exp=0/0/0/1", a_wb_valid, a_wb_data, a_state, a_in_ready); end
  endtask

  task automatic test_xlen64();
    // LD at 0x8
    @(negedge clk);
    b_issue(64'h8, 5'd4, 1'b1, 3'b011);
    #1;
    total++; if (b_mem_req_valid !== 1'b1 || b_mem_req_addr !== 32'h8)
      begin bad++; $display("FAIL ld64_req got=%b/%h exp=1/8", b_mem_req_valid, b_mem_req_addr); end
    @(negedge clk);
    b_idle();
    b_mem_rsp_valid = 1'b1;
    b_mem_rsp_data  = 64'h8000_0000_0000_0001;
    @(negedge clk);
    b_idle();
    total++; if (b_wb_valid !== 1'b1 || b_wb_data !== 64'h8000_0000_0000_0001)
      begin bad++; $display("FAIL ld64_data got=%b/%h exp=1/8000000000000001", b_wb_valid, b_wb_data); end
    // LWU at 0xC: upper word of the same doubleword
    b_issue(64'hC, 5'd6, 1'b1, 3'b110);
    #1;
    total++; if (b_mem_req_valid !== 1'b1 || b_mem_req_addr !== 32'h8)
      begin bad++; $display("FAIL lwu64_req got=%b/%h exp=1/8", b_mem_req_valid, b_mem_req_addr); end
    @(negedge clk);
    b_idle();
    b_mem_rsp_valid = 1'b1;
    b_mem_rsp_data  = 64'h8000_0000_1234_5678;
    @(negedge clk);
    b_idle();
    total++; if (b_wb_valid !== 1'b1 || b_wb_data !== 64'h0000_0000_8000_0000 || b_wb_rd !== 5'd6)
      begin bad++; $display("FAIL lwu64_data got=%b/%h/%0d exp=1/0000000080000000/6", b_wb_valid, b_wb_data, b_wb_rd); end
    // LD at 0x4 is misaligned
    b_issue(64'h4, 5'd4, 1'b1, 3'b011);
    #1;
    total++; if (b_mem_req_valid !== 1'b0) begin bad++; $display("FAIL ld64_mis_noreq got=%b exp=0", b_mem_req_valid); end
    @(negedge clk);
    b_idle();
    total++; if (b_exc !== 1'b1 || b_exc_addr !== 64'h4 || b_wb_en !== 1'b0)
      begin bad++; $display("FAIL ld64_mis_exc got=%b/%h/%b exp=1/4/0", b_exc, b_exc_addr, b_wb_en); end
  endtask

  // -------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------
  initial begin
    a_idle(); b_idle();
    test_reset();
    test_alu_op();
    test_back_to_back();
    test_load_byte(3'b000, 32'hFFFF_FF80, "lb");
    test_load_byte(3'b100, 32'h0000_0080, "lbu");
    test_store_backpressure();
    test_misalign();
    test_reset_in_wait();
    test_xlen64();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
